// File: rtl/button_event_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : button_event_arbiter_if
// Brief   : Valid/ready event port carrying the index of a granted button.
// Revision: 1.0 - initial release
// ============================================================================
interface button_event_arbiter_if #(
    parameter int N_BTN = 4
) ();
    localparam int c_ID_W = $clog2(N_BTN);

    logic              ev_valid;
    logic              ev_ready;
    logic [c_ID_W-1:0] ev_id;

    modport master (output ev_valid, output ev_id, input  ev_ready);
    modport slave  (input  ev_valid, input  ev_id, output ev_ready);
endinterface
`default_nettype wire

// File: rtl/button_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : button_event_arbiter
// Brief   : Turns debounced active-low button levels into round-robin press events
//           with a post-accept hold-off window and a saturating drop counter.
// Revision: 1.0 - initial release
// ============================================================================
module button_event_arbiter #(
    parameter int N_BTN   = 4,
    parameter int HOLDOFF = 8,
    parameter int CNT_W   = 8
) (
    input  wire logic                 m_clock,
    input  wire logic                 m_reset,
    input  wire logic [N_BTN-1:0]     m_state_in,
    input  wire logic                 m_enable,
    button_event_arbiter_if.master    ev,
    output logic      [N_BTN-1:0]     m_pending,
    output logic      [CNT_W-1:0]     m_drop_count
);
    localparam int c_ID_W = $clog2(N_BTN);
    localparam int c_HO_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OFFER = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t              r_state, w_state_nx;
    logic [N_BTN-1:0]    r_prev, r_pending;
    logic [N_BTN-1:0]    w_press, w_set, w_clear, w_drop, w_pending_nx;
    logic [c_ID_W-1:0]   r_last, r_id, w_pick, w_idx, w_id_nx, w_last_nx;
    logic                r_valid, w_valid_nx, w_any;
    logic [c_HO_W-1:0]   r_cnt, w_cnt_nx;
    logic [CNT_W-1:0]    r_drop_cnt;

    // Round-robin: scan downward so the nearest set bit after r_last is kept last.
    always_comb begin
        w_pick = '0;
        w_idx  = '0;
        w_any  = |r_pending;
        for (int k = N_BTN; k >= 1; k--) begin
            w_idx = c_ID_W'((int'(r_last) + k) % N_BTN);
            if (r_pending[w_idx]) begin
                w_pick = w_idx;
            end
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_valid_nx = r_valid;
        w_id_nx    = r_id;
        w_last_nx  = r_last;
        w_cnt_nx   = r_cnt;
        w_clear    = '0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_id_nx         = w_pick;
                    w_valid_nx      = 1'b1;
                    w_clear[w_pick] = 1'b1;
                    w_state_nx      = S_OFFER;
                end
            end
            S_OFFER: begin
                if (ev.ev_ready) begin
                    w_valid_nx = 1'b0;
                    w_last_nx  = r_id;
                    if (HOLDOFF == 0) begin
                        w_state_nx = S_IDLE;
                    end else begin
                        w_state_nx = S_HOLD;
                        w_cnt_nx   = c_HO_W'(HOLDOFF - 1);
                    end
                end
            end
            S_HOLD: begin
                if (r_cnt == '0) begin
                    w_state_nx = S_IDLE;
                end else begin
                    w_cnt_nx = r_cnt - 1'b1;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // A press on a bit being granted this cycle re-arms it rather than dropping.
    always_comb begin
        w_press      = r_prev & ~m_state_in;
        w_set        = m_enable ? w_press : '0;
        w_drop       = w_set & r_pending & ~w_clear;
        w_pending_nx = (r_pending & ~w_clear) | w_set;
    end

    always_ff @(posedge m_clock) begin
        if (m_reset) begin
            r_state    <= S_IDLE;
            r_prev     <= '1;
            r_pending  <= '0;
            r_last     <= c_ID_W'(N_BTN - 1);
            r_id       <= '0;
            r_valid    <= 1'b0;
            r_cnt      <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_prev    <= m_state_in;
            r_pending <= w_pending_nx;
            r_last    <= w_last_nx;
            r_id      <= w_id_nx;
            r_valid   <= w_valid_nx;
            r_cnt     <= w_cnt_nx;
            if ((|w_drop) && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    assign ev.ev_valid    = r_valid;
    assign ev.ev_id       = r_id;
    assign m_pending      = r_pending;
    assign m_drop_count   = r_drop_cnt;
endmodule
`default_nettype wire

// File: tb/tb_button_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_button_event_arbiter
// Brief   : Scoreboard bench for button_event_arbiter against a behavioural model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_button_event_arbiter;
    localparam int N_BTN   = 4;
    localparam int HOLDOFF = 8;
    localparam int CNT_W   = 8;
    localparam int c_SAT   = (1 << CNT_W) - 1;

    typedef struct {
        bit valid;
        int id;
        int pend;
        int drop;
    } stat_t;

    logic             m_clock;
    logic             m_reset;
    logic [N_BTN-1:0] tb_st;
    logic             tb_en;
    logic             tb_rdy;
    logic [N_BTN-1:0] m_pending;
    logic [CNT_W-1:0] m_drop_count;

    button_event_arbiter_if #(.N_BTN(N_BTN)) ev_bus ();
    assign ev_bus.ev_ready = tb_rdy;

    button_event_arbiter #(
        .N_BTN   (N_BTN),
        .HOLDOFF (HOLDOFF),
        .CNT_W   (CNT_W)
    ) dut (
        .m_clock      (m_clock),
        .m_reset      (m_reset),
        .m_state_in   (tb_st),
        .m_enable     (tb_en),
        .ev           (ev_bus),
        .m_pending    (m_pending),
        .m_drop_count (m_drop_count)
    );

    initial m_clock = 1'b0;
    always #5 m_clock = ~m_clock;

    int    n_cmp  = 0;
    int    n_fail = 0;
    stat_t stat_q[$];
    int    ev_q[$];

    // Reference model state: what the outputs must be after each clock edge.
    bit [N_BTN-1:0] md_prev;
    bit [N_BTN-1:0] md_pend;
    bit             md_valid;
    int             md_id, md_last, md_drop, md_wait;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit any_drop;
        int pick;
        if (m_reset) begin
            if (md_valid && ev_q.size() > 0) ev_q.delete(ev_q.size() - 1);
            md_prev  = '1;
            md_pend  = '0;
            md_valid = 0;
            md_id    = 0;
            md_last  = N_BTN - 1;
            md_drop  = 0;
            md_wait  = 0;
        end else begin
            if (md_valid) begin
                if (tb_rdy) begin
                    md_valid = 0;
                    md_last  = md_id;
                    md_wait  = HOLDOFF;
                end
            end else if (md_wait > 0) begin
                md_wait--;
            end else begin
                pick = -1;
                for (int k = 1; k <= N_BTN; k++) begin
                    if (pick < 0 && md_pend[(md_last + k) % N_BTN]) pick = (md_last + k) % N_BTN;
                end
                if (pick >= 0) begin
                    md_id         = pick;
                    md_valid      = 1;
                    md_pend[pick] = 0;
                    ev_q.push_back(pick);
                end
            end
            any_drop = 0;
            if (tb_en) begin
                for (int i = 0; i < N_BTN; i++) begin
                    if (md_prev[i] && !tb_st[i]) begin
                        if (md_pend[i]) any_drop = 1;
                        else            md_pend[i] = 1;
                    end
                end
            end
            if (any_drop && md_drop < c_SAT) md_drop++;
            md_prev = tb_st;
        end
        stat_q.push_back('{valid: md_valid, id: md_id, pend: int'(md_pend), drop: md_drop});
    endtask

    // Inputs change just after an edge; the model then evaluates that next edge.
    task automatic step(input logic [N_BTN-1:0] st, input logic en, input logic rdy, input logic rst);
        tb_st   = st;
        tb_en   = en;
        tb_rdy  = rdy;
        m_reset = rst;
        @(posedge m_clock);
        #1;
        model_edge();
    endtask

    task automatic hold(input int n, input logic [N_BTN-1:0] st, input logic en, input logic rdy);
        for (int i = 0; i < n; i++) step(st, en, rdy, 1'b0);
    endtask

    // Monitor: checks post-edge state and scores each handshake against the queue.
    initial begin
        stat_t s;
        int    e;
        forever begin
            @(negedge m_clock);
            if (stat_q.size() > 0) begin
                s = stat_q.pop_front();
                chk("ev_valid", int'(ev_bus.ev_valid), int'(s.valid));
                chk("m_pending", int'(m_pending), s.pend);
                chk("m_drop_count", int'(m_drop_count), s.drop);
                if (s.valid) chk("ev_id_offer", int'(ev_bus.ev_id), s.id);
            end
            if (ev_bus.ev_valid === 1'b1 && tb_rdy && !m_reset) begin
                if (ev_q.size() == 0) begin
                    chk("unexpected_event", int'(ev_bus.ev_id), -1);
                end else begin
                    e = ev_q.pop_front();
                    chk("ev_id_accept", int'(ev_bus.ev_id), e);
                end
            end
        end
    end

    initial begin
        logic [N_BTN-1:0] lv;
        logic             en;
        md_prev = '1; md_pend = '0; md_valid = 0;
        md_id = 0; md_last = N_BTN - 1; md_drop = 0; md_wait = 0;

        for (int i = 0; i < 3; i++) step('1, 1'b1, 1'b1, 1'b1);

        // Single press on btn2.
        hold(4, 4'b1111, 1, 1);
        hold(4, 4'b1011, 1, 1);
        hold(15, 4'b1111, 1, 1);

        // Simultaneous presses on 0, 1 and 3.
        hold(40, 4'b0100, 1, 1);
        hold(2, 4'b1111, 1, 1);

        // Stalled consumer, re-presses of btn1.
        hold(2, 4'b1111, 1, 0);
        hold(2, 4'b1101, 1, 0);
        hold(3, 4'b1111, 1, 0);
        hold(2, 4'b1101, 1, 0);
        hold(2, 4'b1111, 1, 0);
        hold(2, 4'b1101, 1, 0);
        hold(12, 4'b1111, 1, 0);
        hold(30, 4'b1111, 1, 1);

        // Fairness between btn0 and btn3.
        for (int i = 0; i < 20; i++) begin
            hold(1, 4'b0110, 1, 1);
            hold(1, 4'b1111, 1, 1);
        end
        hold(30, 4'b1111, 1, 1);

        // Capture disabled, then one normal press.
        hold(2, 4'b0000, 0, 1);
        hold(3, 4'b1111, 0, 1);
        hold(1, 4'b1110, 1, 1);
        hold(15, 4'b1111, 1, 1);

        // Reset while offering btn2.
        hold(2, 4'b1011, 1, 0);
        hold(3, 4'b1111, 1, 0);
        step(4'b1111, 1'b1, 1'b0, 1'b1);
        hold(3, 4'b1111, 1, 1);

        // Drop counter saturation behind a stalled offer.
        hold(3, 4'b1110, 1, 0);
        for (int i = 0; i < 320; i++) begin
            hold(1, 4'b1100, 1, 0);
            hold(1, 4'b1110, 1, 0);
        end
        step(4'b1111, 1'b1, 1'b1, 1'b1);
        hold(3, 4'b1111, 1, 1);

        // Randomised traffic.
        lv = '1;
        en = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N_BTN; b++) begin
                if ($urandom_range(0, 3) == 0) lv[b] = ~lv[b];
            end
            if ($urandom_range(0, 15) == 0) en = ($urandom_range(0, 4) != 0);
            step(lv, en, ($urandom_range(0, 3) != 0), ($urandom_range(0, 299) == 0));
        end

        hold(40, 4'b1111, 1, 1);
        @(negedge m_clock);
        #1;
        chk("leftover_events", ev_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
